// File: rtl/fsm_debounce_pkg.sv
// Shared definitions for the debounce front end: FSM state encoding and
// legal parameter bounds.
package fsm_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    PEND_HIGH   = 2'b01,
    STABLE_HIGH = 2'b11,
    PEND_LOW    = 2'b10
  } db_state_t;

  localparam int unsigned SYNC_STAGES_MIN     = 2;
  localparam int unsigned SYNC_STAGES_MAX     = 4;
  localparam int unsigned DEBOUNCE_CYCLES_MIN = 2;
  localparam int unsigned GLITCH_W_MIN        = 1;

endpackage

// File: rtl/sync_ff_chain.sv
// Plain flop chain that brings an asynchronous input into the clk domain.
module sync_ff_chain
  import fsm_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_ff_chain: SYNC_STAGES out of range");
  end

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= '0;
    else      chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/fsm_debounce_sync.sv
// Synchronises a raw input and debounces it with a 4-state FSM; reports an
// open debounce window and counts aborted windows (saturating).
module fsm_debounce_sync
  import fsm_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned GLITCH_W        = 8,
  localparam int unsigned CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din_raw,
  output logic                dout,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN || GLITCH_W < GLITCH_W_MIN) begin : g_bad_params
    $error("fsm_debounce_sync: parameter below legal minimum");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  db_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dout_n, busy_n, glitch_hit;
  logic [GLITCH_W-1:0] glitch_n;

  sync_ff_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din_raw),
    .q   (s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= STABLE_LOW;
      cnt        <= '0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dout       <= dout_n;
      busy       <= busy_n;
      glitch_cnt <= glitch_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    dout_n     = dout;
    glitch_hit = 1'b0;
    case (state)
      STABLE_LOW: if (s) begin
        state_n = PEND_HIGH;
        cnt_n   = CNT_W'(1);
      end
      PEND_HIGH: begin
        if (!s) begin
          state_n    = STABLE_LOW;
          cnt_n      = '0;
          glitch_hit = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n = STABLE_HIGH;
          dout_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STABLE_HIGH: if (!s) begin
        state_n = PEND_LOW;
        cnt_n   = CNT_W'(1);
      end
      PEND_LOW: begin
        if (s) begin
          state_n    = STABLE_HIGH;
          cnt_n      = '0;
          glitch_hit = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n = STABLE_LOW;
          dout_n  = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = STABLE_LOW;
        cnt_n   = '0;
        dout_n  = 1'b0;
      end
    endcase

    // busy is registered from the next state so it lines up with state itself
    busy_n   = (state_n == PEND_HIGH) || (state_n == PEND_LOW);
    glitch_n = (glitch_hit && (glitch_cnt != '1)) ? glitch_cnt + 1'b1 : glitch_cnt;
  end

endmodule

// File: tb/tb_fsm_debounce_sync.sv
// Randomised and directed bench for fsm_debounce_sync; two instances with
// different parameters are checked against a run-length reference model.
module tb_fsm_debounce_sync;

  localparam int S_A = 2, D_A = 16, G_A = 8;
  localparam int S_B = 3, D_B = 4,  G_B = 2;

  logic clk = 1'b0;
  logic rst, din_a, din_b;
  logic dout_a, busy_a, dout_b, busy_b;
  logic [G_A-1:0] gl_a;
  logic [G_B-1:0] gl_b;

  always #5 clk = ~clk;

  fsm_debounce_sync #(.SYNC_STAGES(S_A), .DEBOUNCE_CYCLES(D_A), .GLITCH_W(G_A)) dut_a (
    .clk(clk), .rst(rst), .din_raw(din_a), .dout(dout_a), .busy(busy_a), .glitch_cnt(gl_a)
  );

  fsm_debounce_sync #(.SYNC_STAGES(S_B), .DEBOUNCE_CYCLES(D_B), .GLITCH_W(G_B)) dut_b (
    .clk(clk), .rst(rst), .din_raw(din_b), .dout(dout_b), .busy(busy_b), .glitch_cnt(gl_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: a sample queue per instance, plus the length of the
  // current run of samples disagreeing with the accepted level.
  int stages[2] = '{S_A, S_B};
  int deb[2]    = '{D_A, D_B};
  int gmax[2]   = '{(1 << G_A) - 1, (1 << G_B) - 1};
  bit pipe_m[2][$];
  bit dout_m[2], busy_m[2];
  int run_m[2], gl_m[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pipe_m[k].delete();
      for (int i = 0; i < stages[k]; i++) pipe_m[k].push_back(1'b0);
      dout_m[k] = 1'b0; busy_m[k] = 1'b0; run_m[k] = 0; gl_m[k] = 0;
    end
  endtask

  task automatic model_edge(input int k, input bit din);
    bit s;
    s = pipe_m[k][stages[k]-1];
    if (s != dout_m[k]) begin
      run_m[k]++;
      if (run_m[k] == deb[k]) begin
        dout_m[k] = s;
        run_m[k]  = 0;
      end
    end else if (run_m[k] > 0) begin
      if (gl_m[k] < gmax[k]) gl_m[k]++;
      run_m[k] = 0;
    end
    busy_m[k] = (run_m[k] > 0);
    void'(pipe_m[k].pop_back());
    pipe_m[k].push_front(din);
  endtask

  task automatic check_all();
    check("a_dout",   dout_a, dout_m[0]);
    check("a_busy",   busy_a, busy_m[0]);
    check("a_glitch", gl_a,   gl_m[0]);
    check("b_dout",   dout_b, dout_m[1]);
    check("b_busy",   busy_b, busy_m[1]);
    check("b_glitch", gl_b,   gl_m[1]);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      model_edge(0, din_a);
      model_edge(1, din_b);
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic a, input logic b, input int n);
    din_a = a; din_b = b;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("ar_dout_a", dout_a, 0);
    check("ar_busy_a", busy_a, 0);
    check("ar_gl_a",   gl_a,   0);
    check("ar_dout_b", dout_b, 0);
    check("ar_busy_b", busy_b, 0);
    check("ar_gl_b",   gl_b,   0);
    model_reset();
    @(negedge clk) rst = 1'b1;
  endtask

  int la, lb, g0, ha, hb, va, vb;

  initial begin
    rst = 1'b0; din_a = 1'b1; din_b = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) step();
    din_a = 1'b0; din_b = 1'b0;
    @(negedge clk) rst = 1'b1;
    drive(0, 0, 8);

    // clean rise on both instances; also enter PEND_HIGH for async reset test
    drive(1, 1, S_A + 3);
    check("pre_busy_a", busy_a, 1);
    async_reset();

    // re-qualification after reset: full latency from edge 1
    la = 0; lb = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == D_A + S_A - 1) check("a_edge17_low", dout_a, 0);
      if (dout_a && la == 0) la = i;
      if (dout_b && lb == 0) lb = i;
    end
    check("a_rise_lat", la, S_A + D_A);
    check("b_rise_lat", lb, S_B + D_B);
    check("a_no_glitch", gl_a, 0);

    // fall path latency
    la = 0; lb = 0;
    din_a = 1'b0; din_b = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (!dout_a && la == 0) la = i;
      if (!dout_b && lb == 0) lb = i;
    end
    check("a_fall_lat", la, S_A + D_A);
    check("b_fall_lat", lb, S_B + D_B);

    // last-cycle abort on B: s high for exactly D_B-1 samples
    g0 = gl_b;
    drive(0, 1, D_B - 1);
    drive(0, 0, 12);
    check("b_lastabort_gl", gl_b, g0 + 1);
    check("b_lastabort_dout", dout_b, 0);

    // bounce then hold on B: aborted window then full latency from last rise
    g0 = gl_b;
    drive(0, 1, 3);
    drive(0, 0, 1);
    din_b = 1'b1; lb = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (dout_b && lb == 0) lb = i;
    end
    check("b_bounce_lat", lb, S_B + D_B);
    check("b_bounce_gl", gl_b, g0 + 1);

    // spike during PEND_LOW on A restarts the window
    drive(1, 0, 25);
    g0 = gl_a;
    drive(0, 0, S_A + 3);
    drive(1, 0, 1);
    drive(0, 0, 30);
    check("a_spike_gl", gl_a, g0 + 1);
    check("a_spike_dout", dout_a, 0);

    // saturation on B, then reset mid-PEND_HIGH
    for (int r = 0; r < 5; r++) begin
      drive(0, 1, 2);
      drive(0, 0, 6);
    end
    check("b_sat", gl_b, 3);
    drive(0, 1, S_B + 2);
    check("b_pend", busy_b, 1);
    async_reset();
    drive(0, 0, 10);

    // randomised level bursts
    ha = 0; hb = 0; va = 0; vb = 0;
    for (int i = 0; i < 1500; i++) begin
      if (ha == 0) begin va = $urandom_range(0, 1); ha = $urandom_range(1, D_A + 6); end
      if (hb == 0) begin vb = $urandom_range(0, 1); hb = $urandom_range(1, D_B + 3); end
      din_a = va[0]; din_b = vb[0];
      ha--; hb--;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_debounce_sync.md
Name: fsm_debounce_sync

Overview:
- Front-end conditioning stage for the positive-edge detector pair (Moore and Mealy).
- Takes a raw asynchronous input (push-button or external pin), synchronises it into clk, and debounces it with a 4-state FSM.
- Drives a clean, glitch-free level `dout` that connects directly to the edge detector's `din`.
- Also reports whether a debounce window is open and counts rejected bounces.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples needed to accept a new level; legal minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of the debounce counter; derived, not overridden.
- GLITCH_W, 8, width of the saturating glitch counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- din_raw  input  1  raw asynchronous input, may bounce.
- dout  output  1  debounced, synchronous level; feeds the edge detector's din.
- busy  output  1  high while in PEND_HIGH or PEND_LOW.
- glitch_cnt  output  GLITCH_W  number of aborted pending windows; saturates at all-ones.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-low. While rst=0, all flops clear immediately, independent of clk.
- Reset values:
  - all synchroniser flops = 0
  - state = STABLE_LOW
  - debounce counter = 0
  - dout = 0, busy = 0, glitch_cnt = 0
- Synchroniser:
  - SYNC_STAGES-deep shift chain on din_raw.
  - Its last flop is `s`, the only signal the FSM reads.
  - No logic between the synchroniser flops.
- FSM states: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW. Encoding lives in the package.
- Transitions, evaluated each rising edge:
  - STABLE_LOW, s=1 → PEND_HIGH, cnt<=1.
  - STABLE_LOW, s=0 → stay.
  - PEND_HIGH, s=0 → STABLE_LOW, cnt<=0, glitch_cnt++ (saturating).
  - PEND_HIGH, s=1, cnt==DEBOUNCE_CYCLES-1 → STABLE_HIGH, dout<=1, cnt<=0.
  - PEND_HIGH, s=1, otherwise → cnt++.
  - STABLE_HIGH and PEND_LOW mirror the above with polarity inverted; dout<=0 on acceptance.
- Outputs:
  - dout is registered and changes only on STABLE_* entry from PEND_*.
  - busy is a registered output and equals (next state is PEND_*).
- Latency: number edge 1 as the first edge that captures a new din_raw level. When din_raw is held, dout changes after edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults, that is edge 18.
- Boundary conditions:
  - An s flip on the exact cycle cnt==DEBOUNCE_CYCLES-1 aborts the window: no dout change, glitch counted.
  - A pulse shorter than DEBOUNCE_CYCLES samples never reaches dout.
  - glitch_cnt at all-ones holds; it does not wrap.
  - Reset mid-PEND returns to STABLE_LOW with dout=0 regardless of din_raw. After release, a high din_raw re-qualifies from scratch: full latency, no glitch counted.
  - After reset deassertion, the first transition is evaluated at the first rising edge.
  - Reset deassertion is assumed synchronous to clk at the top level; this is not handled here.

Decomposition:
- Package fsm_debounce_pkg holds:
  - state typedef / localparams STABLE_LOW=2'b00, PEND_HIGH=2'b01, STABLE_HIGH=2'b11, PEND_LOW=2'b10
  - minimum-legal-value constants for the parameters
- One sub-module, sync_ff_chain:
  - parameterised by SYNC_STAGES
  - ports clk, rst, d, q
  - reusable for other async inputs
- Debounce FSM, counter and glitch counter stay in fsm_debounce_sync.

Test Plan:
1. Reset: hold rst=0 with din_raw=1 for 5 cycles → dout=0, busy=0, glitch_cnt=0. Assert rst=0 asynchronously between edges → outputs clear without waiting for a clock edge.
2. Clean rise (defaults): din_raw 0→1 held → busy=1 from edge 3, dout=1 after edge 18, busy=0 after edge 18. dout stays 0 after edge 17.
3. Bounce (DEBOUNCE_CYCLES=4): din_raw high for 3 cycles, low, then high held → first window aborted, glitch_cnt=1. dout rises 6 edges after the final rising edge of din_raw is captured.
4. Last-cycle abort (DEBOUNCE_CYCLES=4): s drops exactly when cnt==3 → dout stays 0, state STABLE_LOW, glitch_cnt increments by 1.
5. Fall path: from dout=1, din_raw 1→0 held → dout=0 after edge SYNC_STAGES+DEBOUNCE_CYCLES. A 1-cycle high spike during PEND_LOW → glitch_cnt+1 and the window restarts.
6. Saturation: GLITCH_W=2, generate 5 aborted windows → glitch_cnt = 3 and stays 3. Then reset mid-PEND_HIGH → dout=0, glitch_cnt=0.
